// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the prefetching fetch unit
package fetch_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int PC_STEP = 4;
    typedef enum logic {RUN, FLUSH} fetch_state_t;
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head reads old data on simultaneous push/pop
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_pop = pop & (count != '0) & ~flush;
    assign do_push = push & ~flush;
    assign head = (count != '0) ? mem[rd_ptr] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited sequential prefetcher with redirect flush feeding a decode FIFO
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_resp_valid_i,
    input  logic [XLEN-1:0] mem_resp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            busy_o,
    output logic            err_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic [CW-1:0] outstanding, drop_cnt, count, drop_next, out_next;
    logic [CW+1:0] used;
    logic [2*XLEN-1:0] head;
    logic err, req_fire, resp_taken, resp_push, pop;
    fetch_state_t state, state_next;
    // every issued or dropped request reserves a FIFO slot, so pushes never overflow
    assign used = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop_cnt);
    assign mem_req_valid_o = rst_ni & enable_i & ~redirect_i & (used < (CW+2)'(FIFO_DEPTH));
    assign mem_addr_o = fetch_pc;
    assign req_fire = mem_req_valid_o & mem_req_ready_i;
    assign resp_taken = mem_resp_valid_i & ((drop_cnt != '0) | (outstanding != '0));
    assign resp_push = mem_resp_valid_i & (drop_cnt == '0) & (outstanding != '0) & ~redirect_i;
    assign pop = instr_valid_o & instr_ready_i & ~redirect_i;
    assign target = redirect_pc_i & ~XLEN'(3);
    assign instr_valid_o = count != '0;
    assign {instr_pc_o, instr_o} = head;
    assign busy_o = (outstanding | drop_cnt) != '0;
    assign err_o = err;
    assign drop_next = redirect_i ? drop_cnt + outstanding - CW'(resp_taken)
                                  : drop_cnt - CW'(mem_resp_valid_i & (drop_cnt != '0));
    assign out_next = redirect_i ? '0 : outstanding + CW'(req_fire) - CW'(resp_push);
    always_comb begin
        state_next = redirect_i ? ((drop_next != '0) ? FLUSH : RUN)
                                : ((drop_next == '0) ? RUN : state);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            err <= 1'b0;
            state <= RUN;
        end else begin
            fetch_pc <= redirect_i ? target : req_fire ? fetch_pc + XLEN'(PC_STEP) : fetch_pc;
            resp_pc <= redirect_i ? target : resp_push ? resp_pc + XLEN'(PC_STEP) : resp_pc;
            outstanding <= out_next;
            drop_cnt <= drop_next;
            err <= err | (mem_resp_valid_i & ~resp_taken);
            state <= state_next;
        end
    end
    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_i),
        .rst_n(rst_ni),
        .push(resp_push),
        .pop(pop),
        .flush(redirect_i),
        .data({resp_pc, mem_resp_data_i}),
        .head(head),
        .count(count)
    );
    assert property (@(posedge clk_i) disable iff (!rst_ni) (state == RUN) |-> (drop_cnt == '0));
endmodule
